// File: rtl/async_fifo.sv
// async_fifo: depth x width single-clock FIFO, async active-low reset, full/empty flags.
// Define FIFO_FWFT_EN for first-word fall-through reads (0-cycle read latency).
module async_fifo #(
  parameter int depth = 8,
  parameter int width = 8,
  parameter int addr  = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [width-1:0] wr_data,
  input  logic             rd,
  output logic [width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [addr:0]      wr_ptr;
  logic [addr:0]      rd_ptr;
  logic [width-1:0]   FIFO [depth];
  logic               wr_en;
  logic               rd_en;
  logic [addr-1:0]    wr_idx;
  logic [addr-1:0]    rd_idx;

  assign wr_idx = wr_ptr[addr-1:0];
  assign rd_idx = rd_ptr[addr-1:0];

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[addr] != rd_ptr[addr]) &&
                 (wr_idx == rd_idx);

  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < depth; i++) begin
        FIFO[i] <= '0;
      end
    end else if (wr_en) begin
      FIFO[wr_idx] <= wr_data;
      wr_ptr       <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
    end else if (rd_en) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  assign rd_data = empty ? '0 : FIFO[rd_idx];
`else
  logic [width-1:0] rd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= FIFO[rd_idx];
    end
  end

  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed + random stimulus against a queue-based FIFO model.
// Works for both the registered and the FIFO_FWFT_EN build.
module tb_async_fifo;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic       wr;
  logic [7:0] wr_data;
  logic       rd;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;

  int total;
  int passed;

  logic [7:0] q[$];
  logic [7:0] mem_m [DEPTH];
  logic [7:0] exp_rd;
  int         wcount;
  int         rcount;

  async_fifo #(.depth(DEPTH), .width(8)) dut (
    .clk(clk),
    .rst(rst),
    .wr(wr),
    .wr_data(wr_data),
    .rd(rd),
    .rd_data(rd_data),
    .full(full),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      passed++;
    end
  endtask

  function automatic logic [7:0] model_rd();
`ifdef FIFO_FWFT_EN
    return (q.size() > 0) ? q[0] : 8'h00;
`else
    return exp_rd;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    exp_rd = 8'h00;
    wcount = 0;
    rcount = 0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, ".rd_data"}, 32'(rd_data), 32'(model_rd()));
  endtask

  // One clock: drive on negedge, sample 1 time unit after posedge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    bit wen;
    bit ren;
    @(negedge clk);
    wr      = w;
    wr_data = d;
    rd      = r;
    @(posedge clk);
    #1;
    wen = w && (q.size() < DEPTH);
    ren = r && (q.size() > 0);
    if (ren) begin
      exp_rd = q.pop_front();
      rcount++;
    end
    if (wen) begin
      q.push_back(d);
      mem_m[wcount % DEPTH] = d;
      wcount++;
    end
    check_status("cyc");
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    rst     = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    wr_data = 8'h00;
    model_reset();

    #12;
    check_status("rst");
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("rst.FIFO%0d", i), 32'(dut.FIFO[i]), 32'h0);
    #1 rst = 1'b1;
    #1 check_status("rel");

    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 8'((i + 1) * 8'h11), 1'b0);
      if (i == 0) check("fill.empty_fall", 32'(empty), 32'h0);
    end
    check("fill.full", 32'(full), 32'h1);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("fill.FIFO%0d", i), 32'(dut.FIFO[i]),
            32'((i + 1) * 8'h11));

    cycle(1'b1, 8'h99, 1'b0);
    check("ovf.FIFO0", 32'(dut.FIFO[0]), 32'h11);
    check("ovf.wr_ptr", 32'(dut.wr_ptr), 32'(wcount % (2 * DEPTH)));
    check("ovf.rd_ptr", 32'(dut.rd_ptr), 32'(rcount % (2 * DEPTH)));
    check("ovf.full", 32'(full), 32'h1);

    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    check("drain.empty", 32'(empty), 32'h1);
    cycle(1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
    check("drain.hold", 32'(rd_data), 32'h88);
`endif

    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap.FIFO%0d", i), 32'(dut.FIFO[i]), 32'(8'hA0 + i));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'(8'hB0 + i), 1'b1);
`ifndef FIFO_FWFT_EN
      check("sim.rd", 32'(rd_data), 32'(8'hA0 + i));
`endif
    end
    check("sim.occ", 32'(q.size()), 32'd4);
    check("sim.wr_ptr", 32'(dut.wr_ptr), 32'(wcount % (2 * DEPTH)));
    for (int i = 4; i < DEPTH; i++)
      check($sformatf("sim.FIFO%0d", i), 32'(dut.FIFO[i]), 32'(8'hB0 + i - 4));

    cycle(1'b0, 8'h00, 1'b1);
    check("mid.occ", 32'(q.size()), 32'd3);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_status("mid");
    check("mid.FIFO4", 32'(dut.FIFO[4]), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
    check("mid.rd5A", 32'(rd_data), 32'h5A);
`endif

    for (int n = 0; n < 400; n++) begin
      logic w;
      logic r;
      int   widx;
      w    = ($urandom_range(0, 99) < 55);
      r    = ($urandom_range(0, 99) < 45);
      widx = wcount % DEPTH;
      cycle(w, 8'($urandom), r);
      check("rnd.mem", 32'(dut.FIFO[widx]), 32'(mem_m[widx]));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- 8-deep x 8-bit FIFO buffer with asynchronous active-low reset and full/empty status flags.
- Sits between a producer and a consumer on the same clock.
- Write side: wr/wr_data. Read side: rd/rd_data.
- Storage array is named FIFO so benches can probe entries hierarchically.

Parameters:
- depth, 8, number of entries; must be a power of 2 and at least 2.
- width, 8, data word width in bits.
- addr, $clog2(depth), storage index width. Pointers are addr+1 bits wide.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr  input  1  write request, sampled at posedge clk.
- wr_data  input  width  data written when a write is accepted.
- rd  input  1  read request, sampled at posedge clk.
- rd_data  output  width  read data.
- full  output  1  high when the FIFO holds depth entries.
- empty  output  1  high when the FIFO holds 0 entries.

Behaviour:
- Interface (decided): one clock; reset is asynchronous and active-low. Ports are clk and rst. rst=0 forces reset immediately, independent of clk.
- Reset values:
  - wr_ptr=0, rd_ptr=0.
  - All FIFO[0..depth-1]=0.
  - rd_data=0, empty=1, full=0.
- Acceptance uses flag values before the clock edge:
  - wr_en = wr & ~full.
  - rd_en = rd & ~empty.
- On posedge clk with wr_en: FIFO[wr_ptr[addr-1:0]] <= wr_data, then wr_ptr += 1.
- On posedge clk with rd_en: rd_data <= FIFO[rd_ptr[addr-1:0]], then rd_ptr += 1.
- rd_data latency is 1 cycle from the accepting edge. rd_data holds its value when there is no accepted read.
- Pointers are (addr+1)-bit binary and wrap modulo 2*depth. The index (low addr bits) wraps modulo depth.
- Flags are combinational from the pointers and update in the same cycle as a pointer change:
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low addr bits are equal.
- Writes while full are dropped silently: no pointer or storage change.
- Reads while empty are ignored: rd_data holds, no pointer change.
- wr and rd together:
  - Neither flag set: both operations happen and the occupancy is unchanged.
  - full: only the read happens, and full deasserts after the edge.
  - empty: only the write happens, and empty deasserts after the edge.
- Reset asserted mid-operation discards all contents and returns every output to its reset value at once. Operation resumes on the first posedge after rst=1.
- No X propagation: every output is defined from reset onward.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - rd_data = FIFO[rd_ptr[addr-1:0]] combinationally whenever empty=0, and 0 when empty=1.
  - rd acts as an acknowledge that advances rd_ptr.
  - Read latency is 0.
- Not defined: registered rd_data with 1-cycle latency, as described above.

Test Plan:
- Reset: hold rst=0 for 13 time units with wr=rd=0.
  - Required: empty=1, full=0, rd_data=0, FIFO[0..7]=0.
  - Then rst=1; flags unchanged.
- Fill: 8 consecutive writes of 0x11..0x88.
  - Required: FIFO[0]=0x11 … FIFO[7]=0x88.
  - empty falls after the first write; full rises after the 8th.
- Overflow: a 9th write of 0x99 while full=1.
  - Required: FIFO[0] stays 0x11, pointers unchanged, full stays 1.
- Drain: 8 reads.
  - Required: rd_data returns 0x11..0x88 in order, each one cycle after its read edge.
  - empty=1 after the 8th read; a 9th read leaves rd_data=0x88.
- Wrap and simultaneous:
  - Write 4 words 0xA0..0xA3 after a full drain; they land in FIFO[0..3].
  - Then hold wr=rd=1 for 4 cycles with data 0xB0..0xB3.
  - Required: occupancy stays 4, reads return 0xA0..0xA3, and the new data occupies FIFO[4..7].
- Reset mid-operation: drop rst to 0 with 3 entries present, then release.
  - Required: empty=1, full=0, rd_data=0 immediately, without waiting for a clock edge.
  - A subsequent write of 0x5A followed by a read returns 0x5A.
